// File: rtl/one_bit_full_adder_if.sv
// Operand/result bundle for one_bit_full_adder.
// carry_cnt exists only when ONE_BIT_FULL_ADDER_CARRY_CNT_EN is defined.
interface one_bit_full_adder_if #(
   parameter int unsigned CNT_W = 16
);
   logic a;
   logic b;
   logic c_in;
   logic in_valid;
   logic sum;
   logic c_out;
   logic out_valid;
`ifdef ONE_BIT_FULL_ADDER_CARRY_CNT_EN
   logic [CNT_W-1:0] carry_cnt;

   modport master (
      output a, b, c_in, in_valid,
      input  sum, c_out, out_valid, carry_cnt
   );

   modport slave (
      input  a, b, c_in, in_valid,
      output sum, c_out, out_valid, carry_cnt
   );
`else
   modport master (
      output a, b, c_in, in_valid,
      input  sum, c_out, out_valid
   );

   modport slave (
      input  a, b, c_in, in_valid,
      output sum, c_out, out_valid
   );
`endif
endinterface

// File: rtl/one_bit_full_adder.sv
// Single-bit full adder with optional output register (REG_OUT) and an optional
// saturating carry-event counter enabled by ONE_BIT_FULL_ADDER_CARRY_CNT_EN.
module one_bit_full_adder #(
   parameter int unsigned REG_OUT = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   one_bit_full_adder_if.slave   bus
);

   // Combinational core: {c_out, sum} = a + b + c_in
   logic sum_c;
   logic c_out_c;

   always_comb begin
      sum_c   = bus.a ^ bus.b ^ bus.c_in;
      c_out_c = (bus.a & bus.b) | (bus.a & bus.c_in) | (bus.b & bus.c_in);
   end

   generate
      if (REG_OUT != 0) begin : g_reg
         logic sum_q;
         logic c_out_q;
         logic out_valid_q;

         // Result loads only on qualified inputs; valid tracks in_valid each cycle
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sum_q       <= 1'b0;
               c_out_q     <= 1'b0;
               out_valid_q <= 1'b0;
            end else begin
               out_valid_q <= bus.in_valid;
               if (bus.in_valid) begin
                  sum_q   <= sum_c;
                  c_out_q <= c_out_c;
               end
            end
         end

         assign bus.sum       = sum_q;
         assign bus.c_out     = c_out_q;
         assign bus.out_valid = out_valid_q;
      end else begin : g_comb
         // Data ignores reset here; only the valid flag is suppressed
         assign bus.sum       = sum_c;
         assign bus.c_out     = c_out_c;
         assign bus.out_valid = bus.in_valid & ~rst;
      end
   endgenerate

`ifdef ONE_BIT_FULL_ADDER_CARRY_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;

   // Counts qualified results that produce a carry, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (bus.in_valid && c_out_c && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_one_bit_full_adder.sv
// Directed bench for one_bit_full_adder: registered and combinational builds
// side by side on shared stimulus, plus the carry counter when its macro is set.
module tb_one_bit_full_adder;

   localparam int unsigned CNT_W = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   one_bit_full_adder_if #(.CNT_W(CNT_W)) bus_r ();
   one_bit_full_adder_if #(.CNT_W(CNT_W)) bus_c ();

   one_bit_full_adder #(.REG_OUT(1), .CNT_W(CNT_W)) u_reg (
      .clk (clk),
      .rst (rst),
      .bus (bus_r.slave)
   );

   one_bit_full_adder #(.REG_OUT(0), .CNT_W(CNT_W)) u_comb (
      .clk (clk),
      .rst (rst),
      .bus (bus_c.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Expected {c_out, sum} indexed by {c_in, b, a}
   logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic a, input logic b, input logic c, input logic v);
      bus_r.a = a; bus_r.b = b; bus_r.c_in = c; bus_r.in_valid = v;
      bus_c.a = a; bus_c.b = b; bus_c.c_in = c; bus_c.in_valid = v;
   endtask

   // Checks the combinational build immediately and the registered one after the next edge
   task automatic apply(input logic a, input logic b, input logic c, input logic v,
                        input logic [2:0] exp_reg, input logic [2:0] exp_comb,
                        input string tag);
      drive(a, b, c, v);
      #1;
      chk({tag, "/comb"}, {1'b0, bus_c.out_valid, bus_c.c_out, bus_c.sum}, {1'b0, exp_comb});
      @(posedge clk);
      #1;
      chk({tag, "/reg"}, {1'b0, bus_r.out_valid, bus_r.c_out, bus_r.sum}, {1'b0, exp_reg});
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a, b, c;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("reset/reg",  {1'b0, bus_r.out_valid, bus_r.c_out, bus_r.sum}, 4'b0000);
      chk("reset/comb", {1'b0, bus_c.out_valid, bus_c.c_out, bus_c.sum}, 4'b0000);
      #1;
      rst = 1'b0;

      // Full truth table, c_in=0 sweep then c_in=1 sweep, back to back
      for (int i = 0; i < 8; i++) begin
         a = i[0]; b = i[1]; c = i[2];
         apply(a, b, c, 1'b1, {1'b1, exp_tab[i]}, {1'b1, exp_tab[i]}, $sformatf("tt%0d", i));
      end

      // Unqualified inputs: registered result holds 1,1 from the 111 vector
      apply(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, "hold0");
      apply(1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 3'b010, "hold1");
      apply(1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 3'b001, "hold2");

      // Asynchronous reset between edges with 111 registered
      apply(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 3'b111, "pre_rst");
      #2;
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      chk("async_rst/reg",  {1'b0, bus_r.out_valid, bus_r.c_out, bus_r.sum}, 4'b0000);
      chk("async_rst/comb", {1'b0, bus_c.out_valid, bus_c.c_out, bus_c.sum}, 4'b0011);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_idle", {1'b0, bus_r.out_valid, bus_r.c_out, bus_r.sum}, 4'b0000);
      apply(1'b1, 1'b0, 1'b0, 1'b1, 3'b101, 3'b101, "post_rst_first");

      // Combinational path responds with no clock edge
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      chk("comb_noclk", {1'b0, bus_c.out_valid, bus_c.c_out, bus_c.sum}, 4'b0110);
      chk("reg_noclk",  {1'b0, bus_r.out_valid, bus_r.c_out, bus_r.sum}, 4'b0101);

`ifdef ONE_BIT_FULL_ADDER_CARRY_CNT_EN
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("cnt_rst0", {2'b00, bus_r.carry_cnt}, 4'd0);
      rst = 1'b0;
      @(negedge clk);
      begin
         logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
         for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 3'b110, $sformatf("cnt_vec%0d", i));
            chk($sformatf("cnt%0d", i), {2'b00, bus_r.carry_cnt}, {2'b00, exp_cnt[i]});
         end
      end
      #2;
      rst = 1'b1;
      #1;
      chk("cnt_rst1", {2'b00, bus_r.carry_cnt}, 4'd0);
      rst = 1'b0;
`endif

      #10;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
